// File: rtl/mips_data_memory_pipelined_if.sv
// Request/response bus between the MEM stage and the pipelined data memory.
// The master issues loads/stores; the slave returns load data and fault status.
interface mips_data_memory_pipelined_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_valid;
    logic        fault;

    modport master (
        output req_valid, mem_read, mem_write, size, unsigned_ld, address, write_data,
        input  req_ready, read_data, read_valid, fault
    );

    modport slave (
        input  req_valid, mem_read, mem_write, size, unsigned_ld, address, write_data,
        output req_ready, read_data, read_valid, fault
    );
endinterface

// File: rtl/mips_data_memory_pipelined.sv
// Big-endian MIPS data memory with byte/half/word access, sign/zero-extended loads,
// alignment/range fault reporting and a READ_LATENCY-deep load result pipeline.
module mips_data_memory_pipelined #(
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    mips_data_memory_pipelined_if.slave        io_bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = {1'b0, 32'(DEPTH_WORDS)} << 2;

    logic [31:0]             r_mem [DEPTH_WORDS];
    logic                    r_ready;
    logic                    r_st_fault;
    logic [READ_LATENCY-1:0] r_pv;
    logic [READ_LATENCY-1:0] r_pf;
    logic [31:0]             r_pd [READ_LATENCY];

    logic          w_accept;
    logic          w_fault;
    logic          w_store;
    logic          w_load;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_rword;
    logic [31:0]   w_byte_sh;
    logic [31:0]   w_half_sh;
    logic [31:0]   w_ld_data;

    assign w_accept = io_bus.req_valid && r_ready && !i_reset;
    assign w_idx    = io_bus.address[AW+1:2];
    assign w_off    = io_bus.address[1:0];
    assign w_store  = w_accept && io_bus.mem_write && !io_bus.mem_read && !w_fault;
    assign w_load   = w_accept && io_bus.mem_read;

    always_comb begin
        w_fault = 1'b0;
        if (io_bus.mem_read && io_bus.mem_write) begin
            w_fault = 1'b1;
        end else if (io_bus.size == 2'b11) begin
            w_fault = 1'b1;
        end else if ((io_bus.size == 2'b01 && w_off[0]) ||
                     (io_bus.size == 2'b10 && w_off != 2'b00)) begin
            w_fault = 1'b1;
        end else if ({1'b0, io_bus.address} >= BYTE_LIMIT) begin
            w_fault = 1'b1;
        end
    end

    // Lane enables: bit 3 is bits [31:24], i.e. byte offset 0 (big-endian).
    always_comb begin
        w_be    = 4'b0000;
        w_wword = '0;
        unique case (io_bus.size)
            2'b00: begin
                w_be    = 4'b1000 >> w_off;
                w_wword = {4{io_bus.write_data[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b0011 : 4'b1100;
                w_wword = {2{io_bus.write_data[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wword = io_bus.write_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    assign w_rword   = r_mem[w_idx];
    assign w_byte_sh = w_rword >> {~w_off, 3'b000};
    assign w_half_sh = w_rword >> {~w_off[1], 4'b0000};

    always_comb begin
        w_ld_data = '0;
        if (!w_fault) begin
            unique case (io_bus.size)
                2'b00:   w_ld_data = {{24{!io_bus.unsigned_ld && w_byte_sh[7]}}, w_byte_sh[7:0]};
                2'b01:   w_ld_data = {{16{!io_bus.unsigned_ld && w_half_sh[15]}}, w_half_sh[15:0]};
                2'b10:   w_ld_data = w_rword;
                default: w_ld_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ready    <= 1'b0;
            r_st_fault <= 1'b0;
            r_pv       <= '0;
            r_pf       <= '0;
            for (int s = 0; s < int'(READ_LATENCY); s++) begin
                r_pd[s] <= '0;
            end
        end else begin
            r_ready    <= 1'b1;
            r_st_fault <= w_accept && io_bus.mem_write && !io_bus.mem_read && w_fault;
            r_pv[0]    <= w_load;
            r_pf[0]    <= w_load && w_fault;
            r_pd[0]    <= w_load ? w_ld_data : '0;
            for (int s = 1; s < int'(READ_LATENCY); s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pf[s] <= r_pf[s-1];
                r_pd[s] <= r_pd[s-1];
            end
        end
    end

    // Outputs are forced idle while reset is held, even before the first reset edge.
    assign io_bus.req_ready  = r_ready && !i_reset;
    assign io_bus.read_valid = r_pv[READ_LATENCY-1] && !i_reset;
    assign io_bus.read_data  = i_reset ? '0 : r_pd[READ_LATENCY-1];
    assign io_bus.fault      = !i_reset &&
                               ((r_pv[READ_LATENCY-1] && r_pf[READ_LATENCY-1]) || r_st_fault);
endmodule

// File: tb/tb_mips_data_memory_pipelined.sv
// Scoreboard bench for mips_data_memory_pipelined: stimulus pushes expected load slots and
// store-fault pulses tagged with their due cycle; a negedge monitor pops and compares.
module tb_mips_data_memory_pipelined;
    localparam int unsigned DEPTH = 256;
    localparam int          LAT   = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_data_memory_pipelined_if bus ();

    mips_data_memory_pipelined #(
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        fault;
    } ld_exp_t;

    ld_exp_t ldq[$];
    int      stq[$];
    int      cyc    = 0;
    int      checks = 0;
    int      errors = 0;
    bit      mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        bit   ld_due;
        bit   st_due;
        logic exp_fault;
        if (mon_en) begin
            ld_due    = (ldq.size() > 0) && (ldq[0].due == cyc);
            st_due    = (stq.size() > 0) && (stq[0] == cyc);
            exp_fault = st_due || (ld_due && ldq[0].fault);
            if (ld_due) begin
                checks++;
                if (bus.read_valid !== 1'b1 || bus.read_data !== ldq[0].data ||
                    bus.fault !== exp_fault) begin
                    errors++;
                    $display("FAIL load_slot cyc=%0d: got valid=%b data=%h fault=%b, want valid=1 data=%h fault=%b",
                             cyc, bus.read_valid, bus.read_data, bus.fault, ldq[0].data, exp_fault);
                end
                void'(ldq.pop_front());
            end else if (bus.read_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid cyc=%0d: got valid=%b data=%h, want valid=0",
                         cyc, bus.read_valid, bus.read_data);
            end
            if (st_due) begin
                checks++;
                if (bus.fault !== 1'b1) begin
                    errors++;
                    $display("FAIL store_fault cyc=%0d: got fault=%b, want 1", cyc, bus.fault);
                end
                void'(stq.pop_front());
            end else if (!ld_due && bus.fault !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL spurious_fault cyc=%0d: got fault=%b, want 0", cyc, bus.fault);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Called at posedge+1; accept happens on the next edge.
    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input bit exp_f, input bit track);
        bus.req_valid   = 1'b1;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.size        = sz;
        bus.unsigned_ld = uns;
        bus.address     = addr;
        bus.write_data  = wd;
        if (track) begin
            if (rd) ldq.push_back('{due: cyc + LAT, data: exp_d, fault: exp_f});
            else if (wr && exp_f) stq.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic ld(input logic [31:0] addr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] exp_d, input bit exp_f);
        issue(1'b1, 1'b0, sz, uns, addr, 32'h0, exp_d, exp_f, 1'b1);
    endtask

    task automatic st(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd,
                      input bit exp_f);
        issue(1'b0, 1'b1, sz, 1'b0, addr, wd, 32'h0, exp_f, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((ldq.size() > 0 || stq.size() > 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (ldq.size() > 0 || stq.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d loads and %0d store faults pending, want 0",
                     ldq.size(), stq.size());
            ldq.delete();
            stq.delete();
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_req_ready", {31'b0, bus.req_ready}, 32'h0);
        chk("reset_read_valid", {31'b0, bus.read_valid}, 32'h0);
        chk("reset_read_data", bus.read_data, 32'h0);
        chk("reset_fault", {31'b0, bus.fault}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'b0, bus.req_ready}, 32'h1);
    endtask

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.size        = 2'b10;
        bus.unsigned_ld = 1'b0;
        bus.address     = '0;
        bus.write_data  = '0;
        mon_en          = 1'b1;
        do_reset();

        // Word store then load in the very next cycle.
        st(32'h4, 2'b10, 32'hDEADBEEF, 1'b0);
        ld(32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

        // Byte merge and byte extension.
        st(32'h8, 2'b10, 32'h11223344, 1'b0);
        st(32'h9, 2'b00, 32'h000000AA, 1'b0);
        ld(32'h9, 2'b00, 1'b1, 32'h000000AA, 1'b0);
        ld(32'h9, 2'b00, 1'b0, 32'hFFFFFFAA, 1'b0);
        ld(32'h8, 2'b10, 1'b0, 32'h11AA3344, 1'b0);

        // Halfword and remaining lane selects.
        st(32'h8, 2'b10, 32'h12348001, 1'b0);
        ld(32'hA, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);
        ld(32'hA, 2'b01, 1'b1, 32'h00008001, 1'b0);
        ld(32'h8, 2'b01, 1'b0, 32'h00001234, 1'b0);
        ld(32'hB, 2'b00, 1'b0, 32'h00000001, 1'b0);
        ld(32'h8, 2'b00, 1'b0, 32'h00000012, 1'b0);

        // Misalignment.
        ld(32'h6, 2'b10, 1'b0, 32'h0, 1'b1);
        ld(32'h1, 2'b01, 1'b0, 32'h0, 1'b1);
        st(32'h0, 2'b10, 32'h55667788, 1'b0);
        st(32'h3, 2'b01, 32'h0000BEEF, 1'b1);
        st(32'h2, 2'b10, 32'hFFFFFFFF, 1'b1);
        ld(32'h0, 2'b10, 1'b0, 32'h55667788, 1'b0);
        st(32'h2, 2'b01, 32'h0000BEEF, 1'b0);
        ld(32'h0, 2'b10, 1'b0, 32'h5566BEEF, 1'b0);
        drain();

        // Back-to-back loads, then reset with two loads in flight.
        ld(32'h0, 2'b10, 1'b0, 32'h5566BEEF, 1'b0);
        ld(32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        ld(32'h8, 2'b10, 1'b0, 32'h12348001, 1'b0);
        drain();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
        do_reset();
        repeat (LAT + 2) @(posedge clk);
        #1;
        ld(32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

        // Range, read+write, reserved size, no-op.
        st(32'h400, 2'b10, 32'h0BADF00D, 1'b1);
        ld(32'h400, 2'b10, 1'b0, 32'h0, 1'b1);
        st(32'h10000004, 2'b10, 32'h0BADF00D, 1'b1);
        ld(32'h10000004, 2'b10, 1'b0, 32'h0, 1'b1);
        st(32'h3FC, 2'b10, 32'hCAFEF00D, 1'b0);
        ld(32'h3FC, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        st(32'h0, 2'b11, 32'hFFFFFFFF, 1'b1);
        ld(32'h4, 2'b11, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        ld(32'h0, 2'b10, 1'b0, 32'h5566BEEF, 1'b0);
        ld(32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
